// File: rtl/t05_pkg.sv
// Shared definitions for the codebook walker and header writer: walk states,
// htree node field layout and the path-length helper.
package t05_pkg;

  localparam logic [2:0] ST_LEFT      = 3'd0;
  localparam logic [2:0] ST_RIGHT     = 3'd1;
  localparam logic [2:0] ST_TRACK     = 3'd2;
  localparam logic [2:0] ST_BACKTRACK = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;
  localparam logic [2:0] ST_INIT      = 3'd5;
  localparam logic [2:0] ST_SEND      = 3'd6;

  localparam int NODE_W    = 71;
  localparam int PATH_W    = 128;
  localparam int LEFT_LSB  = 55;
  localparam int RIGHT_LSB = 46;

  localparam logic FLAG_INTERNAL = 1'b1;

  typedef struct packed {
    logic       flag;
    logic [7:0] val;
  } child_t;

  // Codewords carry a sentinel 1 just above the last path bit, so the
  // codeword length is the position of the highest set bit.
  function automatic logic [6:0] sentinel_pos(input logic [PATH_W-1:0] p);
    logic [6:0] r;
    r = 7'd0;
    for (int i = 0; i < PATH_W; i++) begin
      if (p[i]) r = 7'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/t05_codebook_walker_if.sv
// Bus between the walker and its neighbours: htree memory port, found-char
// handshake and the serial header stream.
interface t05_codebook_walker_if;
  import t05_pkg::*;

  logic [6:0]        max_index;
  logic [NODE_W-1:0] h_element;
  logic              write_finish;
  logic [6:0]        curr_index;
  logic [PATH_W-1:0] char_path;
  logic [7:0]        char_index;
  logic              char_found;
  logic [8:0]        ser_header;
  logic              ser_bit;
  logic              ser_enable;
  logic              ser_done;

  modport master (
    input  max_index, h_element, write_finish,
    output curr_index, char_path, char_index, char_found,
    output ser_header, ser_bit, ser_enable, ser_done
  );

  modport slave (
    output max_index, h_element, write_finish,
    input  curr_index, char_path, char_index, char_found,
    input  ser_header, ser_bit, ser_enable, ser_done
  );

endinterface

// File: rtl/t05_header_synthesis.sv
// Serialises one codeword: latches {1, char} as the header, then shifts the
// path bits below the sentinel out LSB first, then pulses write_finish.
module t05_header_synthesis
  import t05_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              char_found,
  input  logic [7:0]        char_index,
  input  logic [PATH_W-1:0] char_path,
  output logic [8:0]        header,
  output logic              bit1,
  output logic              enable,
  output logic              write_finish
);

  logic [PATH_W-1:0] shift_reg;
  logic [6:0]        remaining;
  logic              active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      header       <= 9'd0;
      bit1         <= 1'b0;
      enable       <= 1'b0;
      write_finish <= 1'b0;
      shift_reg    <= '0;
      remaining    <= 7'd0;
      active       <= 1'b0;
    end else begin
      enable       <= 1'b0;
      write_finish <= 1'b0;
      if (char_found) begin
        header    <= {1'b1, char_index};
        shift_reg <= char_path;
        remaining <= sentinel_pos(char_path);
        active    <= 1'b1;
      end else if (active) begin
        if (remaining == 7'd0) begin
          write_finish <= 1'b1;
          active       <= 1'b0;
        end else begin
          bit1      <= shift_reg[0];
          enable    <= 1'b1;
          shift_reg <= shift_reg >> 1;
          remaining <= remaining - 7'd1;
        end
      end
    end
  end

endmodule

// File: rtl/t05_codebook_walker.sv
// Left-first DFS over the Huffman tree held in htree memory; emits each leaf's
// codeword and re-descends from the root to reach the next right branch.
module t05_codebook_walker
  import t05_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  t05_codebook_walker_if.master bus,
  output logic [2:0]            curr_state,
  output logic [PATH_W-1:0]     curr_path,
  output logic [6:0]            track_length,
  output logic [6:0]            pos,
  output logic [8:0]            least1,
  output logic [8:0]            least2,
  output logic                  wait_cycle,
  output logic [3:0]            finished
);

  logic [6:0]        node_index;
  logic [7:0]        char_index_q;
  logic [PATH_W-1:0] char_path_q;
  logic              char_found_q;
  logic              sent;
  child_t            left_c;
  child_t            right_c;
  logic [6:0]        depth_dec;
  logic              last_bit;
  logic [7:0]        leaf_val;
  logic [PATH_W-1:0] sentinel;
  logic              unused_node_bits;

  assign left_c    = child_t'(bus.h_element[LEFT_LSB +: 9]);
  assign right_c   = child_t'(bus.h_element[RIGHT_LSB +: 9]);
  assign least1    = bus.h_element[LEFT_LSB +: 9];
  assign least2    = bus.h_element[RIGHT_LSB +: 9];
  assign depth_dec = track_length - 7'd1;
  assign last_bit  = curr_path[depth_dec];
  assign leaf_val  = last_bit ? right_c.val : left_c.val;
  assign sentinel  = 128'd1 << track_length;

  assign unused_node_bits = ^{bus.h_element[70:64], bus.h_element[45:0]};

  assign bus.curr_index = node_index;
  assign bus.char_index = char_index_q;
  assign bus.char_path  = char_path_q;
  assign bus.char_found = char_found_q;

  // Every address change spends one cycle with wait_cycle high so the
  // registered htree read can settle before the node is evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curr_state   <= ST_INIT;
      node_index   <= 7'd0;
      curr_path    <= '0;
      track_length <= 7'd0;
      pos          <= 7'd0;
      wait_cycle   <= 1'b0;
      finished     <= 4'd0;
      char_index_q <= 8'd0;
      char_path_q  <= '0;
      char_found_q <= 1'b0;
      sent         <= 1'b0;
    end else begin
      char_found_q <= 1'b0;
      wait_cycle   <= 1'b0;
      if (!wait_cycle) begin
        case (curr_state)
          ST_INIT: begin
            node_index   <= bus.max_index;
            wait_cycle   <= (bus.max_index != node_index);
            curr_path    <= '0;
            track_length <= 7'd0;
            pos          <= 7'd0;
            curr_state   <= ST_LEFT;
          end
          ST_LEFT: begin
            curr_path[track_length] <= 1'b0;
            track_length            <= track_length + 7'd1;
            if (left_c.flag == FLAG_INTERNAL) begin
              node_index <= left_c.val[6:0];
              wait_cycle <= 1'b1;
            end else begin
              curr_state <= ST_SEND;
            end
          end
          ST_RIGHT: begin
            curr_path[track_length] <= 1'b1;
            track_length            <= track_length + 7'd1;
            if (right_c.flag == FLAG_INTERNAL) begin
              node_index <= right_c.val[6:0];
              wait_cycle <= 1'b1;
              curr_state <= ST_LEFT;
            end else begin
              curr_state <= ST_SEND;
            end
          end
          ST_SEND: begin
            if (!sent) begin
              char_index_q <= leaf_val;
              char_path_q  <= sentinel | (curr_path & (sentinel - 128'd1));
              char_found_q <= 1'b1;
              sent         <= 1'b1;
            end else if (bus.write_finish) begin
              sent       <= 1'b0;
              curr_state <= ST_BACKTRACK;
            end
          end
          // A popped left turn means the sibling right subtree is still unvisited.
          ST_BACKTRACK: begin
            track_length <= depth_dec;
            if (!last_bit) begin
              node_index <= bus.max_index;
              wait_cycle <= (bus.max_index != node_index);
              pos        <= 7'd0;
              curr_state <= ST_TRACK;
            end else if (depth_dec == 7'd0) begin
              curr_state <= ST_FINISH;
            end
          end
          ST_TRACK: begin
            if (pos == track_length) begin
              curr_state <= ST_RIGHT;
            end else begin
              node_index <= curr_path[pos] ? right_c.val[6:0] : left_c.val[6:0];
              wait_cycle <= 1'b1;
              pos        <= pos + 7'd1;
            end
          end
          ST_FINISH: begin
            finished <= 4'd1;
          end
          default: begin
            curr_state <= ST_INIT;
          end
        endcase
      end
    end
  end

  t05_header_synthesis u_header (
    .clk          (clk),
    .rst          (rst),
    .char_found   (char_found_q),
    .char_index   (char_index_q),
    .char_path    (char_path_q),
    .header       (bus.ser_header),
    .bit1         (bus.ser_bit),
    .enable       (bus.ser_enable),
    .write_finish (bus.ser_done)
  );

endmodule

// File: tb/tb_t05_codebook_walker.sv
// Bench for t05_codebook_walker: directed trees plus random trees checked
// against a stack-based DFS model of the codeword table.
module tb_t05_codebook_walker;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   curr_state;
  logic [127:0] curr_path;
  logic [6:0]   track_length;
  logic [6:0]   pos;
  logic [8:0]   least1;
  logic [8:0]   least2;
  logic         wait_cycle;
  logic [3:0]   finished;

  logic [70:0]  htree [0:127];
  logic [7:0]   exp_char [$];
  logic [127:0] exp_path [$];
  int           exp_len [$];

  int   passed;
  int   total;
  logic mon_en;
  logic prev_valid;
  logic [6:0] prev_index;
  logic [2:0] prev_state;
  logic prev_wait;

  always #5 clk = ~clk;

  t05_codebook_walker_if bus ();

  t05_codebook_walker dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .curr_state   (curr_state),
    .curr_path    (curr_path),
    .track_length (track_length),
    .pos          (pos),
    .least1       (least1),
    .least2       (least2),
    .wait_cycle   (wait_cycle),
    .finished     (finished)
  );

  // Registered htree read: data follows the address by one clock.
  always @(posedge clk) bus.h_element <= htree[bus.curr_index];

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_valid = 1'b0;
    end else begin
      if (mon_en === 1'b1 && prev_valid === 1'b1) begin
        if (bus.curr_index !== prev_index)
          check_output("wait_after_index", 128'(wait_cycle), 128'(1));
        if (prev_wait === 1'b1)
          check_output("hold_on_wait", 128'(curr_state), 128'(prev_state));
      end
      prev_index = bus.curr_index;
      prev_state = curr_state;
      prev_wait  = wait_cycle;
      prev_valid = 1'b1;
    end
  end

  function automatic logic [8:0] leaf(input logic [7:0] c);
    return {1'b0, c};
  endfunction

  function automatic logic [8:0] inode(input int i);
    return {1'b1, 8'(i)};
  endfunction

  function automatic logic [127:0] code_to_path(input string s);
    logic [127:0] p;
    p = 128'd1 << s.len();
    for (int i = 0; i < s.len(); i++) if (s[i] == 8'h31) p[i] = 1'b1;
    return p;
  endfunction

  task automatic set_expect(input string order, input string codes[$]);
    exp_char.delete(); exp_path.delete(); exp_len.delete();
    for (int i = 0; i < order.len(); i++) begin
      exp_char.push_back(order[i]);
      exp_path.push_back(code_to_path(codes[i]));
      exp_len.push_back(codes[i].len());
    end
  endtask

  task automatic load_directed();
    htree[0] = {7'd8, leaf("C"), leaf("B"), 46'd11};
    htree[1] = {7'd8, leaf("D"), leaf("E"), 46'd12};
    htree[2] = {7'd8, leaf("H"), leaf("I"), 46'd13};
    htree[3] = {7'd8, inode(0), leaf("A"), 46'd14};
    htree[4] = {7'd8, leaf("F"), inode(1), 46'd15};
    htree[5] = {7'd8, leaf("G"), inode(2), 46'd16};
    htree[6] = {7'd8, inode(3), inode(4), 46'd17};
    htree[7] = {7'd8, leaf("J"), inode(5), 46'd18};
    htree[8] = {7'd8, inode(6), inode(7), 46'd19};
    set_expect("CBAFDEJGHI", '{"0000", "0001", "001", "010", "0110", "0111", "10", "110", "1110", "1111"});
  endtask

  // Random full binary tree: merge random pairs from a pool until one root remains.
  task automatic load_random(input int nleaves, output logic [6:0] root);
    logic [8:0] pool [$];
    logic [8:0] a, b;
    logic [7:0] base;
    int idx, k;
    base = 8'($urandom);
    for (int i = 0; i < nleaves; i++) pool.push_back({1'b0, base + 8'(i * 7)});
    k = 0;
    while (pool.size() > 1) begin
      idx = $urandom_range(0, pool.size() - 1); a = pool[idx]; pool.delete(idx);
      idx = $urandom_range(0, pool.size() - 1); b = pool[idx]; pool.delete(idx);
      htree[k] = {7'(nleaves - 2), a, b, 46'($urandom)};
      pool.push_back(inode(k));
      k++;
    end
    root = 7'(k - 1);
  endtask

  task automatic build_model(input logic [6:0] root);
    logic [8:0]   st_f [$];
    logic [127:0] st_p [$];
    int           st_l [$];
    logic [8:0]   f;
    logic [127:0] p;
    int           l;
    exp_char.delete(); exp_path.delete(); exp_len.delete();
    st_f.push_back(htree[root][54:46]); st_p.push_back(128'd1); st_l.push_back(1);
    st_f.push_back(htree[root][63:55]); st_p.push_back(128'd0); st_l.push_back(1);
    while (st_f.size() > 0) begin
      f = st_f.pop_back(); p = st_p.pop_back(); l = st_l.pop_back();
      if (f[8]) begin
        st_f.push_back(htree[f[6:0]][54:46]); st_p.push_back(p | (128'd1 << l)); st_l.push_back(l + 1);
        st_f.push_back(htree[f[6:0]][63:55]); st_p.push_back(p); st_l.push_back(l + 1);
      end else begin
        exp_char.push_back(f[7:0]);
        exp_path.push_back(p | (128'd1 << l));
        exp_len.push_back(l);
      end
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] root);
    @(negedge clk);
    rst = 1'b1;
    bus.write_finish = 1'b0;
    bus.max_index = root;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset(input string w);
    check_output({w, "_state"}, 128'(curr_state), 128'(5));
    check_output({w, "_index"}, 128'(bus.curr_index), 128'(0));
    check_output({w, "_path"}, curr_path, 128'(0));
    check_output({w, "_depth"}, 128'(track_length), 128'(0));
    check_output({w, "_pos"}, 128'(pos), 128'(0));
    check_output({w, "_wait"}, 128'(wait_cycle), 128'(0));
    check_output({w, "_finished"}, 128'(finished), 128'(0));
    check_output({w, "_found"}, 128'(bus.char_found), 128'(0));
    check_output({w, "_char"}, 128'(bus.char_index), 128'(0));
    check_output({w, "_cpath"}, bus.char_path, 128'(0));
    check_output({w, "_ser_en"}, 128'(bus.ser_enable), 128'(0));
  endtask

  task automatic run_walk(input int stall_idx);
    int t, n, delay, extra;
    logic [127:0] ser_bits;
    for (int k = 0; k < exp_char.size(); k++) begin
      t = 0;
      while (bus.char_found !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
      check_output($sformatf("found_%0d", k), 128'(t < 3000), 128'(1));
      if (t >= 3000) return;
      check_output($sformatf("char_%0d", k), 128'(bus.char_index), 128'(exp_char[k]));
      check_output($sformatf("code_%0d", k), bus.char_path, exp_path[k]);
      check_output("least1", 128'(least1), 128'(bus.h_element[63:55]));
      check_output("least2", 128'(least2), 128'(bus.h_element[54:46]));
      @(negedge clk);
      check_output("found_pulse", 128'(bus.char_found), 128'(0));
      ser_bits = '0; n = 0; t = 0;
      while (bus.ser_done !== 1'b1 && t < 300) begin
        if (bus.ser_enable === 1'b1 && n < 128) begin ser_bits[n] = bus.ser_bit; n++; end
        @(negedge clk); t++;
      end
      check_output("ser_done", 128'(t < 300), 128'(1));
      check_output($sformatf("ser_bits_%0d", k), ser_bits, exp_path[k] & ((128'd1 << exp_len[k]) - 128'd1));
      check_output("ser_len", 128'(n), 128'(exp_len[k]));
      check_output("ser_header", 128'(bus.ser_header), 128'({1'b1, exp_char[k]}));
      delay = (k == stall_idx) ? 20 : $urandom_range(0, 3);
      extra = 0;
      repeat (delay) begin @(negedge clk); if (bus.char_found === 1'b1) extra++; end
      check_output("send_hold", 128'(curr_state), 128'(6));
      check_output("no_repulse", 128'(extra), 128'(0));
      bus.write_finish = 1'b1;
      @(negedge clk);
      bus.write_finish = 1'b0;
    end
    t = 0; extra = 0;
    while (finished !== 4'd1 && t < 3000) begin
      @(negedge clk); t++;
      if (bus.char_found === 1'b1) extra++;
    end
    check_output("finished", 128'(finished), 128'(1));
    check_output("finish_state", 128'(curr_state), 128'(4));
    check_output("no_extra_chars", 128'(extra), 128'(0));
  endtask

  initial begin
    int t;
    logic [6:0] root;
    passed = 0; total = 0; mon_en = 1'b0; prev_valid = 1'b0;
    for (int i = 0; i < 128; i++) htree[i] = '0;
    bus.max_index = 7'd0;
    bus.write_finish = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("reset");

    $display("[TB] directed 10-char tree");
    load_directed();
    apply_stimulus(7'd8);
    mon_en = 1'b1;
    run_walk(-1);

    $display("[TB] stall in SEND");
    apply_stimulus(7'd8);
    run_walk(2);

    $display("[TB] two-leaf root");
    htree[0] = {7'd0, leaf("X"), leaf("Y"), 46'd3};
    set_expect("XY", '{"0", "1"});
    apply_stimulus(7'd0);
    run_walk(0);

    $display("[TB] reset during TRACK");
    load_directed();
    apply_stimulus(7'd8);
    t = 0;
    while (curr_state !== 3'd2 && t < 3000) begin
      @(negedge clk);
      bus.write_finish = bus.ser_done;
      t++;
    end
    check_output("reach_track", 128'(t < 3000), 128'(1));
    bus.write_finish = 1'b0;
    #3 rst = 1'b1;
    #1 check_reset("abort");
    apply_stimulus(7'd8);
    run_walk(-1);

    for (int r = 0; r < 4; r++) begin
      load_random($urandom_range(2, 24), root);
      build_model(root);
      $display("[TB] random tree %0d root=%0d leaves=%0d", r, root, exp_char.size());
      apply_stimulus(root);
      run_walk(-1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
